// File: rtl/i2s_master_trx.sv
// I2S bus master transceiver (Philips format).
// Generates bclk and lrclk from sys_clk, serialises a one-deep held stereo
// sample onto dout and deserialises din into rx_l/rx_r once per frame.
// lrclk low selects the left channel; each sample's MSB follows one bclk after
// the lrclk edge.
module i2s_master_trx #(
    parameter int SAMPLE_SIZE = 16,
    parameter int SLOT_BITS   = 32,
    parameter int BCLK_DIV    = 8
) (
    input  logic                   sys_clk,
    input  logic                   reset,
    input  logic                   enable,
    output logic                   bclk,
    output logic                   lrclk,
    output logic                   dout,
    input  logic                   din,
    input  logic [SAMPLE_SIZE-1:0] tx_l,
    input  logic [SAMPLE_SIZE-1:0] tx_r,
    input  logic                   tx_valid,
    output logic                   tx_ready,
    output logic [SAMPLE_SIZE-1:0] rx_l,
    output logic [SAMPLE_SIZE-1:0] rx_r,
    output logic                   rx_valid,
    output logic                   underrun
);

    localparam int DW = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
    localparam int BW = $clog2(2 * SLOT_BITS);
    localparam int KW = $clog2(SLOT_BITS);
    localparam int IW = (SAMPLE_SIZE > 1) ? $clog2(SAMPLE_SIZE) : 1;

    localparam logic [DW-1:0] DIV_LAST = DW'(BCLK_DIV - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(2 * SLOT_BITS - 1);
    localparam logic [BW-1:0] SLOT_B   = BW'(SLOT_BITS);
    localparam logic [KW-1:0] SS_K     = KW'(SAMPLE_SIZE);

    logic [DW-1:0]          div_q, div_d;
    logic                   bclk_q, bclk_d;
    logic                   lrclk_q, lrclk_d;
    logic                   dout_q, dout_d;
    logic [BW-1:0]          bit_q, bit_d;
    logic                   primed_q, primed_d;
    logic                   holdFull_q, holdFull_d;
    logic [SAMPLE_SIZE-1:0] holdL_q, holdL_d, holdR_q, holdR_d;
    logic [SAMPLE_SIZE-1:0] shL_q, shL_d, shR_q, shR_d;
    logic [SAMPLE_SIZE-1:0] rxShL_q, rxShL_d, rxShR_q, rxShR_d;
    logic [SAMPLE_SIZE-1:0] rxL_q, rxL_d, rxR_q, rxR_d;
    logic                   rxValid_q, rxValid_d;
    logic                   underrun_q, underrun_d;

    logic                   divLast, fallEdge, riseEdge, frameStart;
    logic [BW-1:0]          bitNext;
    logic [KW-1:0]          kNext, kCur;
    logic [IW-1:0]          idxNext;

    // Edge detection and slot position decode shared by TX, RX and holding logic
    always_comb begin
        divLast    = (div_q == DIV_LAST);
        fallEdge   = enable && divLast && bclk_q;
        riseEdge   = enable && divLast && !bclk_q;
        bitNext    = (bit_q == BIT_LAST) ? '0 : bit_q + 1'b1;
        kNext      = (bitNext >= SLOT_B) ? KW'(bitNext - SLOT_B) : KW'(bitNext);
        kCur       = (bit_q >= SLOT_B) ? KW'(bit_q - SLOT_B) : KW'(bit_q);
        idxNext    = IW'(SS_K - kNext);
        frameStart = fallEdge && (bitNext == '0);
    end

    // Next-state logic: clock generation, serialiser, deserialiser and TX holding register
    always_comb begin
        div_d      = div_q;
        bclk_d     = bclk_q;
        lrclk_d    = lrclk_q;
        dout_d     = dout_q;
        bit_d      = bit_q;
        primed_d   = primed_q;
        holdFull_d = holdFull_q;
        holdL_d    = holdL_q;
        holdR_d    = holdR_q;
        shL_d      = shL_q;
        shR_d      = shR_q;
        rxShL_d    = rxShL_q;
        rxShR_d    = rxShR_q;
        rxL_d      = rxL_q;
        rxR_d      = rxR_q;
        rxValid_d  = 1'b0;
        underrun_d = 1'b0;

        if (!enable) begin
            div_d    = '0;
            bclk_d   = 1'b0;
            lrclk_d  = 1'b0;
            dout_d   = 1'b0;
            bit_d    = BIT_LAST;
            primed_d = 1'b0;
        end else begin
            div_d = divLast ? '0 : div_q + 1'b1;
            if (divLast) begin
                bclk_d = !bclk_q;
            end
            if (fallEdge) begin
                bit_d   = bitNext;
                lrclk_d = (bitNext >= SLOT_B);
                dout_d  = 1'b0;
                if (kNext >= KW'(1) && kNext <= SS_K) begin
                    dout_d = (bitNext >= SLOT_B) ? shR_q[idxNext] : shL_q[idxNext];
                end
                if (frameStart) begin
                    if (holdFull_q) begin
                        shL_d = holdL_q;
                        shR_d = holdR_q;
                    end else begin
                        shL_d      = '0;
                        shR_d      = '0;
                        underrun_d = 1'b1;
                    end
                    if (primed_q) begin
                        rxL_d     = rxShL_q;
                        rxR_d     = rxShR_q;
                        rxValid_d = 1'b1;
                    end
                    primed_d = 1'b1;
                end
            end
            if (riseEdge && kCur >= KW'(1) && kCur <= SS_K) begin
                if (bit_q >= SLOT_B) begin
                    rxShR_d = {rxShR_q[SAMPLE_SIZE-2:0], din};
                end else begin
                    rxShL_d = {rxShL_q[SAMPLE_SIZE-2:0], din};
                end
            end
        end

        if (frameStart && holdFull_q) begin
            holdFull_d = 1'b0;
        end else if (tx_valid && !holdFull_q) begin
            holdL_d    = tx_l;
            holdR_d    = tx_r;
            holdFull_d = 1'b1;
        end
    end

    // State registers with synchronous reset that aborts any frame in progress
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            div_q      <= '0;
            bclk_q     <= 1'b0;
            lrclk_q    <= 1'b0;
            dout_q     <= 1'b0;
            bit_q      <= BIT_LAST;
            primed_q   <= 1'b0;
            holdFull_q <= 1'b0;
            holdL_q    <= '0;
            holdR_q    <= '0;
            shL_q      <= '0;
            shR_q      <= '0;
            rxShL_q    <= '0;
            rxShR_q    <= '0;
            rxL_q      <= '0;
            rxR_q      <= '0;
            rxValid_q  <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            div_q      <= div_d;
            bclk_q     <= bclk_d;
            lrclk_q    <= lrclk_d;
            dout_q     <= dout_d;
            bit_q      <= bit_d;
            primed_q   <= primed_d;
            holdFull_q <= holdFull_d;
            holdL_q    <= holdL_d;
            holdR_q    <= holdR_d;
            shL_q      <= shL_d;
            shR_q      <= shR_d;
            rxShL_q    <= rxShL_d;
            rxShR_q    <= rxShR_d;
            rxL_q      <= rxL_d;
            rxR_q      <= rxR_d;
            rxValid_q  <= rxValid_d;
            underrun_q <= underrun_d;
        end
    end

    assign bclk     = bclk_q;
    assign lrclk    = lrclk_q;
    assign dout     = dout_q;
    assign tx_ready = !holdFull_q;
    assign rx_l     = rxL_q;
    assign rx_r     = rxR_q;
    assign rx_valid = rxValid_q;
    assign underrun = underrun_q;

endmodule
